eth_pkt_tx_arb: RTL

Parametrised N-channel packet arbiter for the 10G MAC transmit path, in the 156.25 MHz core clock domain. Each upstream channel offers packets on a pkt_tx-style beat interface. The block grants one channel at a time in round-robin order, locks the grant for the whole packet, and drives the MAC `pkt_tx_*` inputs through one output register stage, honouring `pkt_tx_full`. It generalises the single-source pkt_tx interface to NUM_CH sources of configurable width, and adds protocol checking and per-channel packet counters.

---
 rtl/eth_pkt_tx_arb.sv | 139 +++++++++++++
 1 files changed

// File: rtl/eth_pkt_tx_arb.sv
// rtl/eth_pkt_tx_arb.sv - round-robin N-channel packet arbiter feeding the 10G MAC pkt_tx interface
module eth_pkt_tx_arb #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 64,
    parameter int MOD_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic                     clk_156m25,
    input  logic                     reset_156m25_n,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_val,
    input  logic [NUM_CH-1:0]        ch_sop,
    input  logic [NUM_CH-1:0]        ch_eop,
    input  logic [NUM_CH*MOD_W-1:0]  ch_mod,
    output logic [NUM_CH-1:0]        ch_rdy,
    input  logic                     pkt_tx_full,
    output logic [DATA_W-1:0]        pkt_tx_data,
    output logic                     pkt_tx_val,
    output logic                     pkt_tx_sop,
    output logic                     pkt_tx_eop,
    output logic [MOD_W-1:0]         pkt_tx_mod,
    output logic                     proto_err,
    output logic [NUM_CH*CNT_W-1:0]  pkt_cnt
);
    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {IDLE, PKT} state_t;

    state_t            state, state_nxt;
    logic [GW-1:0]     grant, last_grant, winner;
    logic              hit, first, accept;
    logic [NUM_CH-1:0] drain;
    logic [DATA_W-1:0] sel_data;
    logic              sel_val, sel_sop, sel_eop;
    logic [MOD_W-1:0]  sel_mod;
    int                rr_start, rr_dist, rr_best;

    // Eligible channel with the smallest rotated distance from last_grant+1 wins.
    always_comb begin
        hit      = 1'b0;
        winner   = '0;
        rr_best  = NUM_CH;
        rr_dist  = 0;
        rr_start = (int'(last_grant) >= NUM_CH - 1) ? 0 : int'(last_grant) + 1;
        for (int i = 0; i < NUM_CH; i++) begin
            rr_dist = (i >= rr_start) ? (i - rr_start) : (i - rr_start + NUM_CH);
            if (ch_val[i] && ch_sop[i] && (rr_dist < rr_best)) begin
                hit     = 1'b1;
                winner  = GW'(i);
                rr_best = rr_dist;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        sel_val  = 1'b0;
        sel_sop  = 1'b0;
        sel_eop  = 1'b0;
        sel_mod  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == GW'(i)) begin
                sel_data = ch_data[i*DATA_W +: DATA_W];
                sel_val  = ch_val[i];
                sel_sop  = ch_sop[i];
                sel_eop  = ch_eop[i];
                sel_mod  = ch_mod[i*MOD_W +: MOD_W];
            end
        end
    end

    assign accept = (state == PKT) && sel_val && !pkt_tx_full;
    // Mid-packet beats arriving while idle are swallowed so they cannot block arbitration.
    assign drain  = (state == IDLE) ? (ch_val & ~ch_sop) : '0;

    always_comb begin
        ch_rdy = '0;
        if (state == IDLE) begin
            ch_rdy = drain;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                ch_rdy[i] = (grant == GW'(i)) && !pkt_tx_full;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (hit) state_nxt = PKT;
            PKT:  if (accept && sel_eop) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            grant       <= '0;
            last_grant  <= GW'(NUM_CH - 1);
            first       <= 1'b0;
            pkt_tx_data <= '0;
            pkt_tx_val  <= 1'b0;
            pkt_tx_sop  <= 1'b0;
            pkt_tx_eop  <= 1'b0;
            pkt_tx_mod  <= '0;
            proto_err   <= 1'b0;
            pkt_cnt     <= '0;
        end else begin
            pkt_tx_val <= accept;
            proto_err  <= (accept && sel_sop && !first) || (|drain);
            if (state == IDLE && hit) begin
                grant <= winner;
                first <= 1'b1;
            end
            if (accept) begin
                first       <= 1'b0;
                pkt_tx_data <= sel_data;
                pkt_tx_sop  <= sel_sop && first;
                pkt_tx_eop  <= sel_eop;
                pkt_tx_mod  <= sel_eop ? sel_mod : '0;
                if (sel_eop) begin
                    last_grant <= grant;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (grant == GW'(i)) begin
                            pkt_cnt[i*CNT_W +: CNT_W] <= pkt_cnt[i*CNT_W +: CNT_W] + 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule
